// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the Sigma/sigma helpers.
// The SHA-224 IV is only compiled when SHA224_MODE_EN is defined.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_ROUNDS,
        S_UPDATE,
        S_WRITE
    } state_t;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam word_t IV256 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

`ifdef SHA224_MODE_EN
    localparam word_t IV224 [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };
`endif

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; state is packed {a,b,c,d,e,f,g,h}, a in the MSBs.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  word_t        k,
    input  word_t        w,
    output logic [255:0] state_out
);

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    always_comb begin
        {a, b, c, d, e, f, g, h} = state_in;
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        state_out = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

endmodule

// File: rtl/sha256_multiblock.sv
// SHA-256 over NUM_OF_WORDS words of shared memory, padding generated in hardware.
// Define SHA224_MODE_EN to add the mode224 port (SHA-224 IV, 7-word digest).
module sha256_multiblock
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
`ifdef SHA224_MODE_EN
    input  logic        mode224,
`endif
    output logic        done,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int NUM_BLOCKS = (NUM_OF_WORDS + 18) / 16;
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [BW-1:0] LAST_BLK = BW'(NUM_BLOCKS - 1);
    localparam logic [15:0] N16 = 16'(NUM_OF_WORDS);
    localparam word_t LEN_BITS = word_t'(32 * NUM_OF_WORDS);

    state_t        state, state_nxt;
    logic [5:0]    cnt;
    logic [BW-1:0] blk;
    logic [15:0]   msg_base, out_base, rd_addr;
    logic [15:0]   g_cap, g_rd, g_nb;
    logic [255:0]  work, round_out;
    word_t         h_reg [8];
    word_t         h_sum [8];
    word_t         w_sr [16];
    word_t         w_in, w_new;
    logic          last_blk;
    logic [2:0]    wr_last;

`ifdef SHA224_MODE_EN
    logic mode_q;
    assign wr_last = mode_q ? 3'd6 : 3'd7;
`else
    assign wr_last = 3'd7;
`endif

    assign mem_clk = clk;

    sha256_round u_round (
        .state_in  (work),
        .k         (K[cnt]),
        .w         (w_sr[0]),
        .state_out (round_out)
    );

    // LOAD captures the word addressed in the previous slot, so the capture index lags cnt by one.
    always_comb begin
        last_blk = (blk == LAST_BLK);
        g_cap    = (16'(blk) << 4) + 16'(cnt) - 16'd1;
        g_rd     = (16'(blk) << 4) + 16'(cnt) + 16'd1;
        g_nb     = (16'(blk) + 16'd1) << 4;
        w_new    = ssig1(w_sr[14]) + w_sr[9] + ssig0(w_sr[1]) + w_sr[0];
        if (last_blk && cnt == 6'd15)
            w_in = '0;
        else if (last_blk && cnt == 6'd16)
            w_in = LEN_BITS;
        else if (g_cap == N16)
            w_in = 32'h8000_0000;
        else if (g_cap > N16)
            w_in = '0;
        else
            w_in = mem_read_data;
        for (int i = 0; i < 8; i++)
            h_sum[i] = h_reg[i] + work[255-32*i -: 32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        done           = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = rd_addr;
        mem_write_data = '0;
        case (state)
            S_IDLE: begin
                done = 1'b1;
                if (start)
                    state_nxt = S_INIT;
            end
            S_INIT:   state_nxt = S_LOAD;
            S_LOAD:   if (cnt == 6'd16) state_nxt = S_ROUNDS;
            S_ROUNDS: if (cnt == 6'd63) state_nxt = S_UPDATE;
            S_UPDATE: state_nxt = last_blk ? S_WRITE : S_LOAD;
            S_WRITE: begin
                mem_we         = 1'b1;
                mem_addr       = out_base + 16'(cnt[2:0]);
                mem_write_data = h_reg[cnt[2:0]];
                if (cnt[2:0] == wr_last)
                    state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            blk      <= '0;
            msg_base <= '0;
            out_base <= '0;
            rd_addr  <= '0;
            work     <= '0;
            for (int i = 0; i < 8; i++)
                h_reg[i] <= '0;
            for (int i = 0; i < 16; i++)
                w_sr[i] <= '0;
`ifdef SHA224_MODE_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    msg_base <= message_addr;
                    out_base <= output_addr;
                    cnt      <= '0;
                    blk      <= '0;
`ifdef SHA224_MODE_EN
                    mode_q   <= mode224;
                    for (int i = 0; i < 8; i++)
                        h_reg[i] <= mode224 ? IV224[i] : IV256[i];
`else
                    for (int i = 0; i < 8; i++)
                        h_reg[i] <= IV256[i];
`endif
                end
                S_INIT: begin
                    for (int i = 0; i < 8; i++)
                        work[255-32*i -: 32] <= h_reg[i];
                    rd_addr <= msg_base;
                end
                S_LOAD: begin
                    if (cnt != 6'd0) begin
                        for (int i = 0; i < 15; i++)
                            w_sr[i] <= w_sr[i+1];
                        w_sr[15] <= w_in;
                    end
                    // Pad slots keep the last real address on the bus.
                    if (cnt < 6'd15 && g_rd < N16)
                        rd_addr <= msg_base + g_rd;
                    cnt <= (cnt == 6'd16) ? 6'd0 : cnt + 6'd1;
                end
                S_ROUNDS: begin
                    work <= round_out;
                    for (int i = 0; i < 15; i++)
                        w_sr[i] <= w_sr[i+1];
                    w_sr[15] <= w_new;
                    cnt <= cnt + 6'd1;
                end
                S_UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        h_reg[i]             <= h_sum[i];
                        work[255-32*i -: 32] <= h_sum[i];
                    end
                    if (!last_blk) begin
                        blk <= blk + 1'b1;
                        if (g_nb < N16)
                            rd_addr <= msg_base + g_nb;
                    end
                end
                S_WRITE: cnt <= (cnt[2:0] == wr_last) ? 6'd0 : cnt + 6'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_multiblock.sv
// Bench: several engine sizes on private memories, checked against a textbook SHA-256 model.
`timescale 1ns/1ps
module tb_sha256_multiblock;

    localparam int NI = 5;
    localparam int NS [NI] = '{20, 13, 14, 1, 29};
    localparam logic [31:0] SENT = 32'hA5A5_0000;

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] TIV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] TIV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_v [NI];
    logic [15:0] maddr_v [NI];
    logic [15:0] oaddr_v [NI];
    logic        mode_v  [NI];
    logic        done_v  [NI];
    logic        mclk_v  [NI];
    logic        we_v    [NI];
    logic [15:0] addr_v  [NI];
    logic [31:0] wdat_v  [NI];
    logic [31:0] rdat_v  [NI];

    logic [31:0] mem [NI][65536];
    bit          rd_seen [NI][65536];
    int          wr_cnt [NI], wr_oob [NI], rd_cnt [NI], rd_oob [NI], exp_nw [NI];
    bit          prev_done [NI];
    logic [15:0] mon_off;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        sha256_multiblock #(.NUM_OF_WORDS(NS[k])) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start          (start_v[k]),
            .message_addr   (maddr_v[k]),
            .output_addr    (oaddr_v[k]),
`ifdef SHA224_MODE_EN
            .mode224        (mode_v[k]),
`endif
            .done           (done_v[k]),
            .mem_clk        (mclk_v[k]),
            .mem_we         (we_v[k]),
            .mem_addr       (addr_v[k]),
            .mem_write_data (wdat_v[k]),
            .mem_read_data  (rdat_v[k])
        );
    end

    // Synchronous memories: read returns the pre-write contents.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            rdat_v[k] <= mem[k][addr_v[k]];
            if (we_v[k])
                mem[k][addr_v[k]] = wdat_v[k];
        end
    end

    // Bus monitor: counts writes anywhere, and distinct read addresses once past the INIT cycle.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (we_v[k]) begin
                wr_cnt[k]++;
                mon_off = addr_v[k] - oaddr_v[k];
                if (int'(mon_off) >= exp_nw[k]) wr_oob[k]++;
            end else if (!done_v[k] && !prev_done[k] && !rd_seen[k][addr_v[k]]) begin
                rd_seen[k][addr_v[k]] = 1'b1;
                rd_cnt[k]++;
                mon_off = addr_v[k] - maddr_v[k];
                if (int'(mon_off) >= NS[k]) rd_oob[k]++;
            end
            prev_done[k] = done_v[k];
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_blocks(input logic [31:0] p[$], input logic [255:0] iv);
        logic [31:0] hh [8];
        logic [31:0] v [8];
        logic [31:0] w [64];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) hh[i] = iv[255-32*i -: 32];
        for (int b = 0; b < p.size() / 16; b++) begin
            for (int t = 0; t < 16; t++) w[t] = p[16*b + t];
            for (int t = 16; t < 64; t++) begin
                s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
            v = hh;
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
                t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int i = 7; i > 0; i--) v[i] = v[i-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) hh[i] = hh[i] + v[i];
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hh[i];
        return r;
    endfunction

    function automatic logic [255:0] sha_ref(input logic [31:0] m[$], input bit m224);
        logic [31:0] p[$];
        p = m;
        p.push_back(32'h8000_0000);
        while (p.size() % 16 != 14) p.push_back('0);
        p.push_back('0);
        p.push_back(32'(32 * m.size()));
        return sha_blocks(p, m224 ? TIV224 : TIV256);
    endfunction

    task automatic clear_mon(input int k);
        for (int a = 0; a < 65536; a++) rd_seen[k][a] = 1'b0;
        wr_cnt[k] = 0; wr_oob[k] = 0; rd_cnt[k] = 0; rd_oob[k] = 0;
        prev_done[k] = 1'b1;
    endtask

    // Called at a negedge with start already driven; returns the number of done-low cycles.
    task automatic wait_done(input int k, output int cyc);
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            if (cyc == 4) start_v[k] = 1'b0;
            if (!done_v[k]) cyc++;
        end while (!done_v[k] && cyc < 20000);
        start_v[k] = 1'b0;
    endtask

    task automatic run_hash(input int k, input logic [15:0] ma, input logic [15:0] oa,
                            input bit m224, input logic [31:0] words[$], input int reps);
        int n, nb, cyc, exp_lat;
        logic [255:0] dig;
        n = NS[k];
        nb = (n + 18) / 16;
        exp_lat = 1 + 82 * nb + (m224 ? 7 : 8);
        dig = sha_ref(words, m224);
        for (int i = 0; i < n; i++) mem[k][16'(ma + i)] = words[i];
        @(negedge clk);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < 8; i++) mem[k][16'(oa + i)] = SENT ^ i;
            clear_mon(k);
            exp_nw[k] = m224 ? 7 : 8;
            maddr_v[k] = ma; oaddr_v[k] = oa; mode_v[k] = m224;
            start_v[k] = 1'b1;
            chk($sformatf("idle_done[%0d]", k), done_v[k], 1'b1);
            wait_done(k, cyc);
            chk($sformatf("latency[%0d]", k), cyc, exp_lat);
            for (int i = 0; i < 8; i++) begin
                if (i == 7 && m224)
                    chk("untouched_7", mem[k][16'(oa + 7)], SENT ^ 7);
                else
                    chk($sformatf("digest[%0d][%0d]", k, i), mem[k][16'(oa + i)], dig[255-32*i -: 32]);
            end
            chk($sformatf("n_writes[%0d]", k), wr_cnt[k], exp_nw[k]);
            chk($sformatf("wr_range[%0d]", k), wr_oob[k], 0);
            chk($sformatf("n_reads[%0d]", k), rd_cnt[k], n);
            chk($sformatf("rd_range[%0d]", k), rd_oob[k], 0);
        end
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] pabc[$];
        logic [15:0] ma;
        for (int k = 0; k < NI; k++) begin
            start_v[k] = 1'b0; maddr_v[k] = '0; oaddr_v[k] = '0; mode_v[k] = 1'b0;
            exp_nw[k] = 8;
            clear_mon(k);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_done", done_v[k], 1'b1);
            chk("rst_we", we_v[k], 1'b0);
            chk("rst_addr", addr_v[k], 16'h0);
            chk("rst_wdata", wdat_v[k], 32'h0);
        end
        @(posedge clk); #1;
        chk("mem_clk", mclk_v[0], 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        pabc = {32'h61626380};
        repeat (14) pabc.push_back('0);
        pabc.push_back(32'd24);
        chk("model_abc", sha_blocks(pabc, TIV256),
            256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);

        q = {}; for (int i = 0; i < 20; i++) q.push_back(32'(i));
        run_hash(0, 16'h0000, 16'h0100, 1'b0, q, 1);
        q = {}; repeat (13) q.push_back(32'hDEADBEEF);
        run_hash(1, 16'h0000, 16'h0100, 1'b0, q, 1);
        q = {}; repeat (14) q.push_back(32'h01234567);
        run_hash(2, 16'h0000, 16'h0100, 1'b0, q, 1);
        q = {32'h61626300};
        run_hash(3, 16'h0000, 16'h0100, 1'b0, q, 1);
        // Message straddles the top of the address space; back-to-back restart.
        q = {}; repeat (NS[4]) q.push_back($urandom());
        run_hash(4, 16'hFFF0, 16'h7FF0, 1'b0, q, 2);

        // Reset around round 30 of block 0, then rerun.
        q = {}; for (int i = 0; i < 20; i++) q.push_back(32'(i));
        for (int i = 0; i < 8; i++) mem[0][16'h0100 + i] = SENT ^ i;
        @(negedge clk);
        clear_mon(0);
        maddr_v[0] = 16'h0000; oaddr_v[0] = 16'h0100; mode_v[0] = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (47) @(negedge clk);
        chk("mid_busy", done_v[0], 1'b0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_done", done_v[0], 1'b1);
        chk("mid_rst_we", we_v[0], 1'b0);
        chk("mid_rst_addr", addr_v[0], 16'h0);
        chk("mid_rst_wdata", wdat_v[0], 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_writes", wr_cnt[0], 0);
        chk("mid_rst_mem", mem[0][16'h0100], SENT);
        run_hash(0, 16'h0000, 16'h0100, 1'b0, q, 1);

        for (int k = 0; k < NI; k++) begin
            q = {}; repeat (NS[k]) q.push_back($urandom());
            ma = 16'($urandom());
            run_hash(k, ma, ma + 16'h8000, 1'b0, q, (k == 2) ? 2 : 1);
        end

`ifdef SHA224_MODE_EN
        q = {}; for (int i = 0; i < 20; i++) q.push_back(32'(i));
        run_hash(0, 16'h0000, 16'h0100, 1'b1, q, 1);
        q = {}; repeat (NS[4]) q.push_back($urandom());
        ma = 16'($urandom());
        run_hash(4, ma, ma + 16'h4000, 1'b1, q, 2);
        run_hash(4, ma, ma + 16'h4000, 1'b0, q, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
